// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Sequencing FSM for a multi-cycle MIPS32 datapath. It steps each
//   instruction through FETCH / DECODE / EXECUTE / MEM / WB, stalls on the
//   memory ready handshake, drives the shared datapath controls and counts
//   retired instructions.
//
//   Optional feature macro: ILLEGAL_OP_TRAP_EN
//     defined   : an illegal opcode parks the FSM in ILLEGAL with Trap=1
//                 until reset (no retire).
//     undefined : an illegal opcode is a NOP (retires, back to FETCH),
//                 and Trap is tied 0.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   Op, Funct             opcode / function fields from IR
//   Zero                  ALU zero flag (used in BRANCH only)
//   MemReady              memory completes the access this cycle
//   MemReq, IorD,
//   MemWrite              memory request, address select, write strobe
//   IRWrite, PCEn, PCSrc  IR load, PC load, PC source select
//   ALUSrcA, ALUSrcB,
//   ALUControl            ALU operand selects and operation
//   RegWrite, RegDst,
//   MemtoReg              register-file write controls
//   Trap                  illegal opcode trapped
//   InstrCount            retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCEn,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             Trap,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    logic              retire;
    logic              pc_write;
    logic              branch;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign InstrCount = count_q;

    // Next-state and Moore output decode
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        MemReq     = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        Trap       = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemReq   = 1'b1;
                ALUSrcB  = 2'b01;
                IRWrite  = MemReady;
                pc_write = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemReq   = 1'b1;
                IorD     = 1'b1;
                MemWrite = MemReady;
                retire   = MemReady;
                if (MemReady) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                case (Funct)
                    6'b100010: ALUControl = ALU_SUB;
                    6'b100100: ALUControl = ALU_AND;
                    6'b100101: ALUControl = ALU_OR;
                    6'b101010: ALUControl = ALU_SLT;
                    default:   ALUControl = ALU_ADD;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ILLEGAL: begin
`ifdef ILLEGAL_OP_TRAP_EN
                Trap    = 1'b1;
                state_d = S_ILLEGAL;
`else
                retire  = 1'b1;
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase

        PCEn = pc_write | (branch & Zero);

        // While reset is held, no memory access or architectural update may
        // leak out even though the state already reads FETCH.
        if (!reset_n) begin
            MemReq   = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCEn     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//   Instruction-level reference: each instruction is expanded into the list
//   of per-cycle control words it must produce (with the memory wait cycles
//   chosen by the bench), then played against the DUT cycle by cycle.
//   Counter is built 4 bits wide so wrap-around is reached quickly.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int unsigned CNT_W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b110;

    logic             clk;
    logic             reset_n;
    logic [5:0]       Op;
    logic [5:0]       Funct;
    logic             Zero;
    logic             MemReady;
    logic             MemReq, IorD, MemWrite, IRWrite, PCEn;
    logic [1:0]       PCSrc;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUControl;
    logic             RegWrite, RegDst, MemtoReg, Trap;
    logic [CNT_W-1:0] InstrCount;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .MemReq(MemReq), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .Trap(Trap), .InstrCount(InstrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [16:0] obs = {MemReq, IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA,
                       ALUSrcB, ALUControl, RegWrite, RegDst, MemtoReg, Trap};

    int n_cmp = 0;
    int n_bad = 0;
    int cnt   = 0;

    typedef struct {
        logic [16:0] ctl;
        logic        rdy;
        logic        z;
        logic        ret;
        string       name;
    } step_t;

    step_t q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mk(input logic mreq, input logic iord, input logic mw,
                                       input logic irw, input logic pcen, input logic [1:0] pcs,
                                       input logic asa, input logic [1:0] asb, input logic [2:0] alu,
                                       input logic rw, input logic rd, input logic m2r,
                                       input logic trap);
        return {mreq, iord, mw, irw, pcen, pcs, asa, asb, alu, rw, rd, m2r, trap};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [16:0] ctl, input logic rdy, input logic z,
                        input logic ret, input string name);
        step_t s;
        s.ctl = ctl; s.rdy = rdy; s.z = z; s.ret = ret; s.name = name;
        q.push_back(s);
    endtask

    // Expand one instruction into its expected cycles, then play it.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw, input logic zb);
        logic trapped;
        trapped = 1'b0;
        q.delete();
        for (int i = 0; i < fw; i++)
            push(mk(1,0,0,0,0,2'b00,0,2'b01,ADD,0,0,0,0), 1'b0, rnd_bit(), 1'b0, "fetch_wait");
        push(mk(1,0,0,1,1,2'b00,0,2'b01,ADD,0,0,0,0), 1'b1, rnd_bit(), 1'b0, "fetch");
        push(mk(0,0,0,0,0,2'b00,0,2'b11,ADD,0,0,0,0), rnd_bit(), rnd_bit(), 1'b0, "decode");
        case (op)
            OP_LW: begin
                push(mk(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0), rnd_bit(), rnd_bit(), 1'b0, "memadr");
                for (int i = 0; i < mw; i++)
                    push(mk(1,1,0,0,0,2'b00,0,2'b00,ADD,0,0,0,0), 1'b0, rnd_bit(), 1'b0, "memrd_wait");
                push(mk(1,1,0,0,0,2'b00,0,2'b00,ADD,0,0,0,0), 1'b1, rnd_bit(), 1'b0, "memrd");
                push(mk(0,0,0,0,0,2'b00,0,2'b00,ADD,1,0,1,0), rnd_bit(), rnd_bit(), 1'b1, "memwb");
            end
            OP_SW: begin
                push(mk(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0), rnd_bit(), rnd_bit(), 1'b0, "memadr");
                for (int i = 0; i < mw; i++)
                    push(mk(1,1,0,0,0,2'b00,0,2'b00,ADD,0,0,0,0), 1'b0, rnd_bit(), 1'b0, "memwr_wait");
                push(mk(1,1,1,0,0,2'b00,0,2'b00,ADD,0,0,0,0), 1'b1, rnd_bit(), 1'b1, "memwr");
            end
            OP_R: begin
                push(mk(0,0,0,0,0,2'b00,1,2'b00,alu_of(fn),0,0,0,0), rnd_bit(), rnd_bit(), 1'b0, "execute");
                push(mk(0,0,0,0,0,2'b00,0,2'b00,ADD,1,1,0,0), rnd_bit(), rnd_bit(), 1'b1, "aluwb");
            end
            OP_BEQ:
                push(mk(0,0,0,0,zb,2'b01,1,2'b00,SUB,0,0,0,0), rnd_bit(), zb, 1'b1, "branch");
            OP_ADDI: begin
                push(mk(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0), rnd_bit(), rnd_bit(), 1'b0, "addiex");
                push(mk(0,0,0,0,0,2'b00,0,2'b00,ADD,1,0,0,0), rnd_bit(), rnd_bit(), 1'b1, "addiwb");
            end
            OP_J:
                push(mk(0,0,0,0,1,2'b10,0,2'b00,ADD,0,0,0,0), rnd_bit(), rnd_bit(), 1'b1, "jump");
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                trapped = 1'b1;
                for (int i = 0; i < 4; i++)
                    push(mk(0,0,0,0,0,2'b00,0,2'b00,ADD,0,0,0,1), rnd_bit(), rnd_bit(), 1'b0, "trap_hold");
`else
                push(mk(0,0,0,0,0,2'b00,0,2'b00,ADD,0,0,0,0), rnd_bit(), rnd_bit(), 1'b1, "illegal_nop");
`endif
            end
        endcase
        foreach (q[i]) begin
            @(negedge clk);
            Op = op; Funct = fn; MemReady = q[i].rdy; Zero = q[i].z;
            #1;
            check_eq({q[i].name, "_ctl"}, 32'(obs), 32'(q[i].ctl));
            check_eq({q[i].name, "_cnt"}, 32'(InstrCount), 32'(cnt));
            if (q[i].ret) cnt = (cnt + 1) % (1 << CNT_W);
        end
        if (trapped) do_reset();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; MemReady = 1'b0;
        #1;
        check_eq("rst_cnt", 32'(InstrCount), 32'd0);
        check_eq("rst_trap", 32'(Trap), 32'd0);
        check_eq("rst_memreq", 32'(MemReq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
    endtask

    // Reset asserted while a store is completing its write.
    task automatic reset_mid_memwr();
        Op = OP_SW; Funct = 6'd0; Zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            MemReady = 1'b1;
        end
        @(negedge clk);
        MemReady = 1'b1;
        #1;
        check_eq("memwr_strobe", 32'(MemWrite), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_memwrite", 32'(MemWrite), 32'd0);
        check_eq("midrst_memreq", 32'(MemReq), 32'd0);
        check_eq("midrst_cnt", 32'(InstrCount), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; MemReady = 1'b0;
        #1;
        check_eq("postrst_fetch", 32'(obs), 32'(mk(1,0,0,0,0,2'b00,0,2'b01,ADD,0,0,0,0)));
        cnt = 0;
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] bad [4];
        logic [5:0] fns [6];
        logic [5:0] op, fn;
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;
        ops[4] = OP_ADDI; ops[5] = OP_J; ops[6] = OP_BAD;
        bad[0] = 6'b111111; bad[1] = 6'b000001; bad[2] = 6'b100000; bad[3] = 6'b001101;
        fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
        fns[3] = 6'b100101; fns[4] = 6'b101010; fns[5] = 6'b000000;

        reset_n = 1'b0; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; MemReady = 1'b0;
        #2;
        check_eq("init_cnt", 32'(InstrCount), 32'd0);
        check_eq("init_trap", 32'(Trap), 32'd0);
        check_eq("init_memreq", 32'(MemReq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed instructions
        run_instr(OP_R, 6'b100000, 0, 0, 1'b0);
        run_instr(OP_LW, 6'd0, 0, 3, 1'b0);
        run_instr(OP_BEQ, 6'd0, 0, 0, 1'b1);
        run_instr(OP_BEQ, 6'd0, 0, 0, 1'b0);
        run_instr(OP_SW, 6'd0, 1, 2, 1'b0);
        run_instr(OP_ADDI, 6'd0, 0, 0, 1'b0);
        run_instr(OP_R, 6'b100010, 2, 0, 1'b0);
`ifndef ILLEGAL_OP_TRAP_EN
        run_instr(OP_BAD, 6'd0, 0, 0, 1'b0);
`endif
        // 16 jumps from a known count exercise the wrap of the 4-bit counter
        for (int i = 0; i < 16; i++) run_instr(OP_J, 6'd0, 0, 0, 1'b0);

        // Randomized instruction stream
        for (int n = 0; n < 120; n++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == OP_BAD) begin
`ifdef ILLEGAL_OP_TRAP_EN
                op = OP_R;
`else
                op = bad[$urandom_range(0, 3)];
`endif
            end
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), rnd_bit());
        end

        reset_mid_memwr();
        run_instr(OP_R, 6'b100101, 0, 0, 1'b0);

`ifdef ILLEGAL_OP_TRAP_EN
        run_instr(OP_BAD, 6'd0, 0, 0, 1'b0);
        run_instr(OP_J, 6'd0, 0, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
